factor_display_seq: RTL and testbench

- Downstream consumer of the factorizer core, sitting between the factor engine and the TinyTapeout 7-segment output (uo_out[6:0] segments, uo_out[7] decimal point).
- Collects one group of 8-bit factors over a valid/ready stream into a small buffer.
- Once the group's last factor arrives, loops forever over the group, showing each factor as two hex digits on the single digit, one dwell period per digit, then a blank gap.
- A new group starts on clear.

---
 rtl/factorizer_pkg.sv | 14 +
 rtl/hex_to_seg.sv | 30 +++
 rtl/factor_display_seq.sv | 120 ++++++++++++
 tb/tb_factor_display_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/factorizer_pkg.sv
// Shared types and constants for the factorizer display path.
package factorizer_pkg;

  localparam int DATA_W = 8;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    COLLECT,
    SHOW_HI,
    SHOW_LO,
    GAP
  } state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-high 7-segment pattern (bit0=a .. bit6=g).
module hex_to_seg (
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'h00;
    case (nibble)
      4'h0: segments = 7'h3F;
      4'h1: segments = 7'h06;
      4'h2: segments = 7'h5B;
      4'h3: segments = 7'h4F;
      4'h4: segments = 7'h66;
      4'h5: segments = 7'h6D;
      4'h6: segments = 7'h7D;
      4'h7: segments = 7'h07;
      4'h8: segments = 7'h7F;
      4'h9: segments = 7'h6F;
      4'hA: segments = 7'h77;
      4'hB: segments = 7'h7C;
      4'hC: segments = 7'h39;
      4'hD: segments = 7'h5E;
      4'hE: segments = 7'h79;
      4'hF: segments = 7'h71;
      default: segments = 7'h00;
    endcase
  end

endmodule

// File: rtl/factor_display_seq.sv
// Buffers one group of factors, then cycles them on a single hex digit:
// high nibble, low nibble (with dp), blank gap, one dwell period each.
module factor_display_seq #(
  parameter int MAX_COUNT = 10_000_000,
  parameter int DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       fac_valid,
  input  logic [7:0] fac_data,
  input  logic       fac_last,
  output logic       fac_ready,
  output logic [6:0] segments,
  output logic       dp,
  output logic       overflow
);
  import factorizer_pkg::*;

  localparam int CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

  state_t           state, state_n;
  logic [LEN_W-1:0] len, len_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ovf_n;
  logic             wr_en;
  logic [DATA_W-1:0] fac_buf [DEPTH];
  logic [3:0]       nibble;
  logic [6:0]       seg_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= COLLECT;
      len      <= '0;
      idx      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      len      <= len_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      overflow <= ovf_n;
    end
  end

  // Buffer contents are only visible in display states, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en) fac_buf[len[IDX_W-1:0]] <= fac_data;
  end

  always_comb begin
    state_n   = state;
    len_n     = len;
    idx_n     = idx;
    cnt_n     = cnt;
    ovf_n     = overflow;
    wr_en     = 1'b0;
    fac_ready = (state == COLLECT) && !clear;

    if (clear) begin
      state_n = COLLECT;
      len_n   = '0;
      idx_n   = '0;
      cnt_n   = '0;
      ovf_n   = 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (fac_valid) begin
            if (len < LEN_FULL) begin
              wr_en = 1'b1;
              len_n = len + LEN_W'(1);
            end else begin
              ovf_n = 1'b1;
            end
            if (fac_last) begin
              state_n = SHOW_HI;
              idx_n   = '0;
              cnt_n   = '0;
            end
          end
        end
        default: begin
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
            case (state)
              SHOW_HI: state_n = SHOW_LO;
              SHOW_LO: state_n = GAP;
              default: begin
                state_n = SHOW_HI;
                idx_n   = (LEN_W'(idx) == len - LEN_W'(1)) ? '0 : idx + IDX_W'(1);
              end
            endcase
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    nibble = (state == SHOW_HI) ? fac_buf[idx][7:4] : fac_buf[idx][3:0];
  end

  hex_to_seg u_hex_to_seg (
    .nibble   (nibble),
    .segments (seg_dec)
  );

  assign segments = (state == SHOW_HI || state == SHOW_LO) ? seg_dec : SEG_BLANK;
  assign dp       = (state == SHOW_LO);

endmodule

// File: tb/tb_factor_display_seq.sv
// Randomized self-checking bench for factor_display_seq against a queue-based display model.
module tb_factor_display_seq;

  localparam int MC = 4;
  localparam int DP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       fac_valid = 1'b0;
  logic [7:0] fac_data = 8'h00;
  logic       fac_last = 1'b0;
  logic       fac_ready;
  logic [6:0] segments;
  logic       dp;
  logic       overflow;

  int total = 0;
  int bad = 0;

  logic [7:0] model_q [$];
  bit         model_ovf = 1'b0;
  int         disp_k = 0;
  logic [7:0] vals [8];

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  factor_display_seq #(.MAX_COUNT(MC), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .fac_valid (fac_valid),
    .fac_data  (fac_data),
    .fac_last  (fac_last),
    .fac_ready (fac_ready),
    .segments  (segments),
    .dp        (dp),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic send_group(input int n, input bit gaps, input string name);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      total++;
      if (fac_ready !== 1'b1) begin
        bad++;
        $display("FAIL %s ready word %0d: got %b want 1", name, i, fac_ready);
      end
      fac_valid = 1'b1;
      fac_data  = vals[i];
      fac_last  = (i == n - 1);
      @(posedge clk);
      #1;
      fac_valid = 1'b0;
      fac_last  = 1'b0;
      if (model_q.size() < DP) model_q.push_back(vals[i]);
      else model_ovf = 1'b1;
    end
    disp_k = 0;
  endtask

  task automatic check_display(input int n, input bit bp, input string name);
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         e, ph;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      e  = (disp_k / (3 * MC)) % model_q.size();
      ph = (disp_k % (3 * MC)) / MC;
      exp_seg = 7'h00;
      exp_dp  = 1'b0;
      if (ph == 0) exp_seg = seg_tab[model_q[e][7:4]];
      if (ph == 1) begin
        exp_seg = seg_tab[model_q[e][3:0]];
        exp_dp  = 1'b1;
      end
      total++;
      if (segments !== exp_seg || dp !== exp_dp) begin
        bad++;
        $display("FAIL %s disp k=%0d: got seg=%h dp=%b want seg=%h dp=%b",
                 name, disp_k, segments, dp, exp_seg, exp_dp);
      end
      total++;
      if (fac_ready !== 1'b0 || overflow !== model_ovf) begin
        bad++;
        $display("FAIL %s flags k=%0d: got ready=%b ovf=%b want ready=0 ovf=%b",
                 name, disp_k, fac_ready, overflow, model_ovf);
      end
      disp_k++;
      if (bp) begin
        fac_valid = 1'b1;
        fac_data  = 8'($urandom);
        fac_last  = 1'($urandom);
      end
    end
    fac_valid = 1'b0;
    fac_last  = 1'b0;
  endtask

  task automatic do_clear(input bit with_valid, input string name);
    @(negedge clk);
    clear     = 1'b1;
    fac_valid = with_valid;
    fac_data  = 8'hEE;
    fac_last  = 1'($urandom);
    @(posedge clk);
    #1;
    clear     = 1'b0;
    fac_valid = 1'b0;
    fac_last  = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    @(negedge clk);
    total++;
    if (segments !== 7'h00 || dp !== 1'b0 || fac_ready !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL %s after clear: got seg=%h dp=%b ready=%b ovf=%b want 00 0 1 0",
               name, segments, dp, fac_ready, overflow);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if (segments !== 7'h00 || dp !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got seg=%h dp=%b ovf=%b want 00 0 0", segments, dp, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (fac_ready !== 1'b1 || segments !== 7'h00) begin
      bad++;
      $display("FAIL reset_release: got ready=%b seg=%h want 1 00", fac_ready, segments);
    end
  endtask

  task automatic test_single;
    vals[0] = 8'h2B;
    send_group(1, 1'b0, "single");
    check_display(3 * MC * 2 + MC, 1'b0, "single");
  endtask

  task automatic test_group;
    do_clear(1'b0, "group");
    vals[0] = 8'h03; vals[1] = 8'h05; vals[2] = 8'h07;
    send_group(3, 1'b0, "group");
    check_display(3 * MC * 4 + 2, 1'b0, "group");
  endtask

  task automatic test_overflow;
    do_clear(1'b0, "overflow");
    for (int i = 0; i < 6; i++) vals[i] = 8'h11 + 8'(i);
    send_group(6, 1'b0, "overflow");
    check_display(3 * MC * 5 + 1, 1'b0, "overflow");
  endtask

  task automatic test_async_reset;
    // Display is in SHOW_HI of 0x12 here, so outputs are non-zero before reset.
    #2 rst = 1'b1;
    #1;
    total++;
    if (segments !== 7'h00 || dp !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got seg=%h dp=%b ovf=%b want 00 0 0", segments, dp, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    @(negedge clk);
    total++;
    if (fac_ready !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_release: got ready=%b ovf=%b want 1 0", fac_ready, overflow);
    end
  endtask

  task automatic test_clear;
    vals[0] = 8'hA6; vals[1] = 8'h4D;
    send_group(2, 1'b0, "clear");
    check_display(MC + 1, 1'b0, "clear");
    do_clear(1'b0, "clear_in_lo");
    do_clear(1'b1, "clear_with_valid");
    vals[0] = 8'h2B;
    send_group(1, 1'b0, "clear_len0");
    check_display(3 * MC * 2, 1'b0, "clear_len0");
  endtask

  task automatic test_back_to_back;
    do_clear(1'b0, "backpressure");
    vals[0] = 8'h9C; vals[1] = 8'hF8; vals[2] = 8'h1E;
    send_group(3, 1'b0, "backpressure");
    check_display(3 * MC * 4, 1'b1, "backpressure");
  endtask

  task automatic test_random;
    int n;
    for (int it = 0; it < 8; it++) begin
      do_clear(1'($urandom), "random");
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) vals[i] = 8'($urandom);
      send_group(n, 1'b1, "random");
      check_display($urandom_range(3 * MC, 3 * MC * 6), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_group();
    test_overflow();
    test_async_reset();
    test_clear();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
